mem_hsiao_scrub: RTL
====================

// Module: mem_hsiao_scrub
// PURPOSE
//  Parametrised storage array for Hsiao SEC-DED codewords, with a background scrubber.
//  The host writes pre-encoded codewords and reads them back with one-cycle registered latency.
//  When enabled, the scrubber walks every entry and hands each stored codeword to an external
//  combinational Hsiao decoder. It writes back single-bit corrections, and counts and flags
//  double-bit errors.
// PARAMETERS
//  CW_W      13  codeword width (data + check bits)
//  DEPTH     16  number of entries, 2..2**ADDR_W
//  ADDR_W     4  address width
//  SCRUB_GAP 64  idle cycles between scrub steps, >=1
//  CNT_W      8  width of the error counters
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous reset, active-high
//  wr_en        in   1        host write strobe
//  rd_en        in   1        host read strobe
//  addr         in   ADDR_W   host address, shared by read and write
//  data_in      in   CW_W     codeword to write
//  data_out     out  CW_W     registered read data
//  rd_valid     out  1        one-cycle pulse; data_out is valid
//  scrub_en     in   1        enable the background scrubber
//  scrub_cw     out  CW_W     codeword currently under check; drives the external decoder
//  scrub_fix_cw in   CW_W     corrected codeword returned by the decoder
//  scrub_sec    in   1        decoder result: single-bit error (correctable)
//  scrub_ded    in   1        decoder result: double-bit error (uncorrectable)
//  clear_cnt    in   1        synchronous clear of the counters and the flag
//  sec_cnt      out  CNT_W    corrected-error count, saturating
//  ded_cnt      out  CNT_W    uncorrectable-error count, saturating
//  ded_flag     out  1        sticky uncorrectable-error flag
//  ded_addr     out  ADDR_W   address of the most recent double-bit error
//  pass_done    out  1        one-cycle pulse when the scrub pointer wraps to 0
// BEHAVIOUR
//  Reset:
//   - All entries, data_out, scrub_cw, counters, flags, pointers and the gap counter go to 0.
//   - FSM goes to S_IDLE. A reset mid-operation abandons any pending writeback.
//   - The all-zero codeword is a valid Hsiao word.
//  Host write:
//   - mem[addr] <= data_in on the rising edge while wr_en is high.
//   - addr >= DEPTH: write ignored.
//  Host read:
//   - rd_en in cycle N gives data_out = mem[addr] and rd_valid=1 in cycle N+1.
//   - data_out holds its value otherwise.
//   - addr >= DEPTH: returns 0.
//   - rd_en and wr_en together: the read returns the pre-write contents.
//  FSM states: S_IDLE, S_WAIT, S_READ, S_CHECK, S_WB.
//   - S_IDLE: when scrub_en=1, go to S_WAIT and load the gap counter with SCRUB_GAP-1.
//   - S_WAIT: count down; at 0 go to S_READ.
//   - S_READ: scrub_cw <= mem[scrub_ptr]; go to S_CHECK.
//   - S_CHECK: sample the decoder inputs.
//     - scrub_sec=1: increment sec_cnt, go to S_WB.
//     - scrub_ded=1: increment ded_cnt, set ded_flag, ded_addr <= scrub_ptr, no writeback.
//     - Otherwise, and in the ded case: advance the pointer, then go to S_WAIT (scrub_en=1)
//       or S_IDLE (scrub_en=0).
//   - S_WB: mem[scrub_ptr] <= scrub_fix_cw, then advance as above.
//  Host priority and collisions:
//   - The host always wins the write port. A host wr_en during S_WB stalls S_WB by one cycle.
//   - A host write to scrub_ptr while in S_READ, S_CHECK or S_WB sets a stale bit.
//   - When stale is set, the writeback is suppressed (host data is newer).
//   - Counters still update from the decoder result.
//  Pointer:
//   - Advances scrub_ptr -> scrub_ptr+1; DEPTH-1 wraps to 0 and pulses pass_done.
//   - The pointer is retained across scrub_en toggles.
//  scrub_en deassert mid-word: finish the current word, including S_WB, then go to S_IDLE.
//  Counters:
//   - Saturate at 2**CNT_W-1.
//   - clear_cnt zeroes sec_cnt, ded_cnt and ded_flag; it wins over a same-cycle increment.
//  scrub_sec and scrub_ded both high: treated as ded.
// CONFIGURATION
//  MEM_HSIAO_FAULT_INJ_EN defined:
//   - Adds input inj_mask [CW_W-1:0].
//   - A host write stores data_in ^ inj_mask. Used to seed errors for scrubber verification.
//  Not defined: the port is absent and a host write stores data_in unmodified.
// TESTING
//  T1: rst; rd_en addr=5 -> next cycle data_out=0, rd_valid=1.
//  T2: write 13'h1A5B to addr 3; rd_en addr 3 -> 13'h1A5B one cycle later.
//  T3: write addr 2; the decoder model flags sec with fix 13'h0F0F; scrub_en=1
//      -> mem[2]=13'h0F0F after the S_WB cycle, sec_cnt=1.
//  T4: decoder flags ded at addr 7 -> ded_cnt=1, ded_flag=1, ded_addr=7, mem[7] unchanged;
//      clear_cnt -> all 0.
//  T5: sec pending at ptr 4; host writes 13'h0001 to addr 4 during S_CHECK
//      -> mem[4]=13'h0001, no writeback, sec_cnt=1.
//  T6: DEPTH=16, SCRUB_GAP=1, clean memory -> pass_done pulses once per full pass,
//      scrub_ptr returns to 0; assert rst mid-S_WB -> everything 0, S_IDLE.

Source files
------------

// File: rtl/mem_hsiao_scrub.sv
// Hsiao SEC-DED codeword store with background scrubber; host reads have 1-cycle registered latency.
// Host always owns the write port and stalls scrub writeback; MEM_HSIAO_FAULT_INJ_EN adds inj_mask.
module mem_hsiao_scrub #(
    parameter int CW_W      = 13,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int SCRUB_GAP = 64,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [CW_W-1:0]   data_in,
    output logic [CW_W-1:0]   data_out,
    output logic              rd_valid,
    input  logic              scrub_en,
    output logic [CW_W-1:0]   scrub_cw,
    input  logic [CW_W-1:0]   scrub_fix_cw,
    input  logic              scrub_sec,
    input  logic              scrub_ded,
    input  logic              clear_cnt,
    output logic [CNT_W-1:0]  sec_cnt,
    output logic [CNT_W-1:0]  ded_cnt,
    output logic              ded_flag,
    output logic [ADDR_W-1:0] ded_addr,
    output logic              pass_done
`ifdef MEM_HSIAO_FAULT_INJ_EN
    ,
    input  logic [CW_W-1:0]   inj_mask
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_READ  = 3'd2,
        S_CHECK = 3'd3,
        S_WB    = 3'd4
    } state_e;

    localparam int                GAP_W    = (SCRUB_GAP > 1) ? $clog2(SCRUB_GAP) : 1;
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(SCRUB_GAP - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [CW_W-1:0]   mem_q [DEPTH];
    logic [CW_W-1:0]   mem_d [DEPTH];
    logic [CW_W-1:0]   data_out_q, data_out_d;
    logic              rd_valid_q, rd_valid_d;
    logic [CW_W-1:0]   scrub_cw_q, scrub_cw_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              stale_q, stale_d;
    logic [CNT_W-1:0]  sec_cnt_q, sec_cnt_d;
    logic [CNT_W-1:0]  ded_cnt_q, ded_cnt_d;
    logic              ded_flag_q, ded_flag_d;
    logic [ADDR_W-1:0] ded_addr_q, ded_addr_d;
    logic              pass_done_q, pass_done_d;

    logic              addr_ok, host_wr, ded_hit, sec_hit;
    logic              ld_cw, chk, wb_go, adv;
    logic [CW_W-1:0]   wr_data;

    assign addr_ok = (int'(addr) < DEPTH);
    assign host_wr = wr_en && addr_ok;
    // A simultaneous sec+ded report is treated as uncorrectable.
    assign ded_hit = scrub_ded;
    assign sec_hit = scrub_sec && !scrub_ded;

`ifdef MEM_HSIAO_FAULT_INJ_EN
    assign wr_data = data_in ^ inj_mask;
`else
    assign wr_data = data_in;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (scrub_en) state_d = S_WAIT;
            S_WAIT: begin
                if (!scrub_en)       state_d = S_IDLE;
                else if (gap_q == 0) state_d = S_READ;
            end
            S_READ:  state_d = S_CHECK;
            S_CHECK: begin
                if (sec_hit) state_d = S_WB;
                else         state_d = scrub_en ? S_WAIT : S_IDLE;
            end
            S_WB:    if (!wr_en) state_d = scrub_en ? S_WAIT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Per-state control strobes
    always_comb begin
        ld_cw = 1'b0;
        chk   = 1'b0;
        wb_go = 1'b0;
        adv   = 1'b0;
        case (state_q)
            S_READ:  ld_cw = 1'b1;
            S_CHECK: begin
                chk = 1'b1;
                adv = !sec_hit;
            end
            S_WB: begin
                adv   = !wr_en;
                wb_go = !wr_en && !stale_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (host_wr)    mem_d[addr]  = wr_data;
        else if (wb_go) mem_d[ptr_q] = scrub_fix_cw;

        rd_valid_d = rd_en;
        data_out_d = data_out_q;
        if (rd_en) data_out_d = addr_ok ? mem_q[addr] : '0;

        scrub_cw_d = ld_cw ? mem_q[ptr_q] : scrub_cw_q;

        ptr_d       = ptr_q;
        pass_done_d = 1'b0;
        if (adv) begin
            ptr_d       = (ptr_q == PTR_LAST) ? '0 : ptr_q + ADDR_W'(1);
            pass_done_d = (ptr_q == PTR_LAST);
        end

        gap_d = gap_q;
        if ((state_q == S_IDLE || adv) && scrub_en) gap_d = GAP_LOAD;
        else if (state_q == S_WAIT && gap_q != 0)   gap_d = gap_q - GAP_W'(1);

        // Host data written after the scrub read is newer than any correction.
        stale_d = stale_q;
        if (adv)
            stale_d = 1'b0;
        else if (host_wr && addr == ptr_q &&
                 (state_q == S_READ || state_q == S_CHECK || state_q == S_WB))
            stale_d = 1'b1;

        sec_cnt_d  = sec_cnt_q;
        ded_cnt_d  = ded_cnt_q;
        ded_flag_d = ded_flag_q;
        ded_addr_d = ded_addr_q;
        if (chk && ded_hit) ded_addr_d = ptr_q;
        if (clear_cnt) begin
            sec_cnt_d  = '0;
            ded_cnt_d  = '0;
            ded_flag_d = 1'b0;
        end else if (chk) begin
            if (sec_hit && sec_cnt_q != CNT_MAX) sec_cnt_d = sec_cnt_q + CNT_W'(1);
            if (ded_hit) begin
                ded_flag_d = 1'b1;
                if (ded_cnt_q != CNT_MAX) ded_cnt_d = ded_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            data_out_q  <= '0;
            rd_valid_q  <= 1'b0;
            scrub_cw_q  <= '0;
            ptr_q       <= '0;
            gap_q       <= '0;
            stale_q     <= 1'b0;
            sec_cnt_q   <= '0;
            ded_cnt_q   <= '0;
            ded_flag_q  <= 1'b0;
            ded_addr_q  <= '0;
            pass_done_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            data_out_q  <= data_out_d;
            rd_valid_q  <= rd_valid_d;
            scrub_cw_q  <= scrub_cw_d;
            ptr_q       <= ptr_d;
            gap_q       <= gap_d;
            stale_q     <= stale_d;
            sec_cnt_q   <= sec_cnt_d;
            ded_cnt_q   <= ded_cnt_d;
            ded_flag_q  <= ded_flag_d;
            ded_addr_q  <= ded_addr_d;
            pass_done_q <= pass_done_d;
        end
    end

    assign data_out  = data_out_q;
    assign rd_valid  = rd_valid_q;
    assign scrub_cw  = scrub_cw_q;
    assign sec_cnt   = sec_cnt_q;
    assign ded_cnt   = ded_cnt_q;
    assign ded_flag  = ded_flag_q;
    assign ded_addr  = ded_addr_q;
    assign pass_done = pass_done_q;

endmodule
